// File: rtl/ids_pkt_gen_pkg.sv
// Shared constants, state encoding and helpers for the ids packet generator.
// Ctrl codes follow the module-header / payload / last-word framing of the ids datapath.
package ids_pkt_gen_pkg;

   localparam logic [7:0] CTRL_HDR     = 8'hFF;
   localparam logic [7:0] CTRL_PAYLOAD = 8'h00;
   localparam logic [7:0] CTRL_LAST    = 8'h01;
   localparam logic [7:0] MIN_LEN      = 8'd2;

   typedef enum logic [1:0] {
      S_IDLE,
      S_HDR,
      S_BODY
   } gen_state_e;

   // Payloads shorter than MIN_LEN are stretched so the body always has a first and last word.
   function automatic logic [7:0] eff_len(input logic [7:0] len);
      return (len < MIN_LEN) ? MIN_LEN : len;
   endfunction

   function automatic logic [15:0] len_bytes(input logic [7:0] len);
      return {5'b0, len, 3'b0};
   endfunction

endpackage

// File: rtl/fallthrough_small_fifo.sv
// Small first-word-fallthrough FIFO: dout shows the head word whenever empty is low.
// nearly_full asserts with one free slot left, giving the writer a cycle of slack.
module fallthrough_small_fifo #(
   parameter int WIDTH          = 72,
   parameter int MAX_DEPTH_BITS = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] din,
   input  logic             wr_en,
   input  logic             rd_en,
   output logic [WIDTH-1:0] dout,
   output logic             nearly_full,
   output logic             empty
);

   localparam int DEPTH = 1 << MAX_DEPTH_BITS;

   logic [WIDTH-1:0]          mem [DEPTH];
   logic [MAX_DEPTH_BITS-1:0] rd_ptr, wr_ptr;
   logic [MAX_DEPTH_BITS:0]   count;
   logic                      full, do_wr, do_rd;

   assign full        = (count == (MAX_DEPTH_BITS+1)'(DEPTH));
   assign empty       = (count == '0);
   assign nearly_full = (count >= (MAX_DEPTH_BITS+1)'(DEPTH-1));
   assign do_wr       = wr_en && !full;
   assign do_rd       = rd_en && !empty;
   assign dout        = mem[rd_ptr];

   // NOTE: storage has no reset; validity is tracked by count, so clearing the array buys nothing.
   always_ff @(posedge clk) begin
      if (do_wr) mem[wr_ptr] <= din;
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_wr) wr_ptr <= wr_ptr + 1'b1;
         if (do_rd) rd_ptr <= rd_ptr + 1'b1;
         case ({do_wr, do_rd})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/ids_pkt_gen.sv
// Injects generated packets into an upstream packet stream at packet boundaries.
// Upstream words pass through a small FIFO; after each injected packet one pass packet may go first.
module ids_pkt_gen
   import ids_pkt_gen_pkg::*;
#(
   parameter int DATA_WIDTH = 64,
   parameter int CTRL_WIDTH = DATA_WIDTH/8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic [CTRL_WIDTH-1:0] in_ctrl,
   input  logic                  in_wr,
   output logic                  in_rdy,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic [CTRL_WIDTH-1:0] out_ctrl,
   output logic                  out_wr,
   input  logic                  out_rdy,
   input  logic                  gen_start,
   input  logic [7:0]            gen_num_pkts,
   input  logic [7:0]            gen_len,
   input  logic [63:0]           gen_pattern,
   output logic                  gen_busy,
   output logic [31:0]           gen_sent
);

   gen_state_e state, next_state;

   logic [7:0]  remaining, len, idx;
   logic [63:0] pattern;
   logic        pass_in_pkt, slot_pending;

   logic [CTRL_WIDTH+DATA_WIDTH-1:0] fifo_dout;
   logic [CTRL_WIDTH-1:0]            fifo_ctrl;
   logic [DATA_WIDTH-1:0]            fifo_data;
   logic                             fifo_empty, fifo_nearly_full, fifo_rd;

   logic                  launch, pkt_done, start_ok;
   logic [CTRL_WIDTH-1:0] launch_ctrl;
   logic [DATA_WIDTH-1:0] launch_data;

   fallthrough_small_fifo #(
      .WIDTH          (CTRL_WIDTH + DATA_WIDTH),
      .MAX_DEPTH_BITS (2)
   ) u_in_fifo (
      .clk         (clk),
      .reset       (reset),
      .din         ({in_ctrl, in_data}),
      .wr_en       (in_wr),
      .rd_en       (fifo_rd),
      .dout        (fifo_dout),
      .nearly_full (fifo_nearly_full),
      .empty       (fifo_empty)
   );

   assign {fifo_ctrl, fifo_data} = fifo_dout;
   assign in_rdy   = !fifo_nearly_full;
   assign gen_busy = (remaining != '0) || (state != S_IDLE);
   assign start_ok = gen_start && (remaining == '0) && (gen_num_pkts != '0);

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      next_state  = state;
      fifo_rd     = 1'b0;
      launch      = 1'b0;
      pkt_done    = 1'b0;
      launch_ctrl = '0;
      launch_data = '0;
      unique case (state)
         S_IDLE: begin
            // A pending pass slot is honoured only if pass traffic is actually waiting.
            if (remaining != '0 && !pass_in_pkt && !(slot_pending && !fifo_empty)) begin
               next_state = S_HDR;
            end else if (!fifo_empty && out_rdy) begin
               fifo_rd     = 1'b1;
               launch      = 1'b1;
               launch_ctrl = fifo_ctrl;
               launch_data = fifo_data;
            end
         end
         S_HDR: begin
            if (out_rdy) begin
               launch      = 1'b1;
               launch_ctrl = CTRL_WIDTH'(CTRL_HDR);
               launch_data = DATA_WIDTH'(len_bytes(len));
               next_state  = S_BODY;
            end
         end
         S_BODY: begin
            if (out_rdy) begin
               launch      = 1'b1;
               launch_data = (idx == 8'd1) ? DATA_WIDTH'(pattern) : DATA_WIDTH'(idx);
               launch_ctrl = (idx == len) ? CTRL_WIDTH'(CTRL_LAST) : CTRL_WIDTH'(CTRL_PAYLOAD);
               if (idx == len) begin
                  pkt_done   = 1'b1;
                  next_state = S_IDLE;
               end
            end
         end
         default: next_state = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= S_IDLE;
         remaining    <= '0;
         len          <= MIN_LEN;
         pattern      <= '0;
         idx          <= '0;
         pass_in_pkt  <= 1'b0;
         slot_pending <= 1'b0;
         gen_sent     <= '0;
         out_wr       <= 1'b0;
         out_data     <= '0;
         out_ctrl     <= '0;
      end else begin
         state  <= next_state;
         out_wr <= launch;
         if (launch) begin
            out_data <= launch_data;
            out_ctrl <= launch_ctrl;
         end

         if (state == S_HDR && out_rdy)                    idx <= 8'd1;
         else if (state == S_BODY && out_rdy && !pkt_done) idx <= idx + 8'd1;

         if (pkt_done) begin
            remaining <= remaining - 8'd1;
            gen_sent  <= gen_sent + 32'd1;
         end else if (start_ok) begin
            remaining <= gen_num_pkts;
            len       <= eff_len(gen_len);
            pattern   <= gen_pattern;
         end

         if (fifo_rd) begin
            if (fifo_ctrl == CTRL_WIDTH'(CTRL_HDR))          pass_in_pkt <= 1'b1;
            else if (fifo_ctrl != CTRL_WIDTH'(CTRL_PAYLOAD)) pass_in_pkt <= 1'b0;
         end

         if (pkt_done)                                          slot_pending <= 1'b1;
         else if (state == S_IDLE && (fifo_empty || fifo_rd))   slot_pending <= 1'b0;
      end
   end

endmodule

// File: tb/tb_ids_pkt_gen.sv
// Directed bench for ids_pkt_gen: captures every output word and compares the stream
// against hand-built expected sequences, plus status and reset checks.
module tb_ids_pkt_gen;

   logic        clk = 1'b0;
   logic        reset;
   logic [63:0] in_data;
   logic [7:0]  in_ctrl;
   logic        in_wr;
   logic        in_rdy;
   logic [63:0] out_data;
   logic [7:0]  out_ctrl;
   logic        out_wr;
   logic        out_rdy;
   logic        gen_start;
   logic [7:0]  gen_num_pkts;
   logic [7:0]  gen_len;
   logic [63:0] gen_pattern;
   logic        gen_busy;
   logic [31:0] gen_sent;

   ids_pkt_gen #(.DATA_WIDTH(64), .CTRL_WIDTH(8)) dut (
      .clk          (clk),
      .reset        (reset),
      .in_data      (in_data),
      .in_ctrl      (in_ctrl),
      .in_wr        (in_wr),
      .in_rdy       (in_rdy),
      .out_data     (out_data),
      .out_ctrl     (out_ctrl),
      .out_wr       (out_wr),
      .out_rdy      (out_rdy),
      .gen_start    (gen_start),
      .gen_num_pkts (gen_num_pkts),
      .gen_len      (gen_len),
      .gen_pattern  (gen_pattern),
      .gen_busy     (gen_busy),
      .gen_sent     (gen_sent)
   );

   always #5 clk = ~clk;

   int          n_cmp = 0;
   int          n_bad = 0;
   int          viol  = 0;
   logic        prev_rdy = 1'b1;
   logic [71:0] cap[$];
   logic [71:0] exp_q[$];

   localparam logic [63:0] PAT_A = 64'h0102030405060708;
   localparam logic [63:0] PAT_B = 64'hDEADBEEF00C0FFEE;

   task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Output monitor: record launched words and any word that ignored out_rdy.
   always @(negedge clk) begin
      if (!reset && out_wr) begin
         cap.push_back({out_ctrl, out_data});
         if (!prev_rdy) viol++;
      end
      prev_rdy = out_rdy;
   end

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   function automatic logic [71:0] pass_word(input int id, input int w, input int n);
      logic [7:0] c;
      c = (w == 0) ? 8'hFF : (w == n-1) ? 8'h02 : 8'h00;
      return {c, 64'hCAFE_0000_0000_0000 | 64'(id << 8) | 64'(w)};
   endfunction

   task automatic add_pass(input int id, input int n);
      for (int w = 0; w < n; w++) exp_q.push_back(pass_word(id, w, n));
   endtask

   task automatic add_inj(input int len, input logic [63:0] pat);
      exp_q.push_back({8'hFF, 64'(len * 8)});
      for (int i = 1; i <= len; i++)
         exp_q.push_back({(i == len) ? 8'h01 : 8'h00, (i == 1) ? pat : 64'(i)});
   endtask

   task automatic send_pkt(input int id, input int n);
      for (int w = 0; w < n; w++) begin
         int waited = 0;
         while (!in_rdy && waited < 200) begin
            in_wr = 1'b0;
            tick();
            waited++;
         end
         if (!in_rdy) begin
            check("send_timeout", 72'(in_rdy), 72'd1);
            in_wr = 1'b0;
            return;
         end
         {in_ctrl, in_data} = pass_word(id, w, n);
         in_wr = 1'b1;
         tick();
      end
      in_wr = 1'b0;
   endtask

   task automatic pulse_start(input logic [7:0] n, input logic [7:0] l, input logic [63:0] p);
      gen_num_pkts = n;
      gen_len      = l;
      gen_pattern  = p;
      gen_start    = 1'b1;
      tick();
      gen_start    = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick(2);
      reset = 1'b0;
      tick();
      cap.delete();
      exp_q.delete();
      viol = 0;
   endtask

   task automatic check_stream(input string tag);
      int n;
      check($sformatf("%s_count", tag), 72'(cap.size()), 72'(exp_q.size()));
      n = (cap.size() < exp_q.size()) ? cap.size() : exp_q.size();
      for (int i = 0; i < n; i++)
         check($sformatf("%s_w%0d", tag, i), cap[i], exp_q[i]);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      in_data = '0; in_ctrl = '0; in_wr = 1'b0; out_rdy = 1'b1;
      gen_start = 1'b0; gen_num_pkts = '0; gen_len = '0; gen_pattern = '0;

      // Reset state
      do_reset();
      check("rst_out_wr",   72'(out_wr),   72'd0);
      check("rst_out_data", 72'(out_data), 72'd0);
      check("rst_out_ctrl", 72'(out_ctrl), 72'd0);
      check("rst_gen_sent", 72'(gen_sent), 72'd0);
      check("rst_gen_busy", 72'(gen_busy), 72'd0);
      check("rst_in_rdy",   72'(in_rdy),   72'd1);

      // Single injection from idle
      pulse_start(8'd1, 8'd3, PAT_A);
      check("t1_busy_on", 72'(gen_busy), 72'd1);
      tick(12);
      add_inj(3, PAT_A);
      check_stream("t1");
      check("t1_sent", 72'(gen_sent), 72'd1);
      check("t1_busy_off", 72'(gen_busy), 72'd0);

      // Start while a 5-word pass packet is in flight
      do_reset();
      fork
         send_pkt(1, 5);
         begin
            tick(2);
            pulse_start(8'd1, 8'd2, PAT_B);
         end
      join
      tick(20);
      add_pass(1, 5);
      add_inj(2, PAT_B);
      check_stream("t2");
      check("t2_sent", 72'(gen_sent), 72'd1);

      // Backpressure: out_rdy alternating every cycle
      do_reset();
      fork
         begin
            for (int c = 0; c < 60; c++) begin
               out_rdy = ~out_rdy;
               tick();
            end
            out_rdy = 1'b1;
         end
         pulse_start(8'd2, 8'd4, PAT_A);
      join
      tick(5);
      add_inj(4, PAT_A);
      add_inj(4, PAT_A);
      check_stream("t3");
      check("t3_rdy_viol", 72'(viol), 72'd0);
      check("t3_sent", 72'(gen_sent), 72'd2);

      // Interleaving with continuous pass traffic
      do_reset();
      fork
         begin
            send_pkt(1, 3);
            send_pkt(2, 3);
            send_pkt(3, 3);
         end
         pulse_start(8'd3, 8'd2, PAT_B);
      join
      tick(40);
      for (int k = 1; k <= 3; k++) begin
         add_inj(2, PAT_B);
         add_pass(k, 3);
      end
      check_stream("t4");
      check("t4_sent", 72'(gen_sent), 72'd3);

      // Limits: zero packets, zero length, start while busy
      do_reset();
      pulse_start(8'd0, 8'd5, PAT_A);
      tick(10);
      check("t5_zero_busy",  72'(gen_busy),   72'd0);
      check("t5_zero_words", 72'(cap.size()), 72'd0);
      pulse_start(8'd1, 8'd0, PAT_A);
      tick();
      pulse_start(8'd2, 8'd7, PAT_B);
      tick(20);
      add_inj(2, PAT_A);
      check_stream("t5");
      check("t5_sent", 72'(gen_sent), 72'd1);
      check("t5_busy_off", 72'(gen_busy), 72'd0);

      // Reset in BODY with idx=2, then pass-through resumes
      do_reset();
      pulse_start(8'd1, 8'd5, PAT_A);
      tick(3);
      reset = 1'b1;
      #1;
      check("t6_out_wr",   72'(out_wr),   72'd0);
      check("t6_gen_sent", 72'(gen_sent), 72'd0);
      check("t6_gen_busy", 72'(gen_busy), 72'd0);
      cap.delete();
      exp_q.delete();
      tick();
      reset = 1'b0;
      tick(2);
      send_pkt(7, 2);
      tick(10);
      add_pass(7, 2);
      check_stream("t6");
      check("t6_sent_after", 72'(gen_sent), 72'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/ids_pkt_gen.md
IDS_PKT_GEN -- requirements
Module: ids_pkt_gen

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, meaning the packet data bus width.
REQ-002 SHALL have parameter CTRL_WIDTH, default DATA_WIDTH/8, meaning the packet ctrl bus width.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have ports in_data, in_ctrl and in_wr: inputs of DATA_WIDTH, CTRL_WIDTH and 1 bits, the upstream packet stream.
REQ-006 SHALL have port in_rdy, output, 1, asserted when upstream may write.
REQ-007 SHALL have ports out_data, out_ctrl and out_wr: outputs of DATA_WIDTH, CTRL_WIDTH and 1 bits, the merged downstream stream.
REQ-008 SHALL have port out_rdy, input, 1, asserted when downstream accepts one word next cycle.
REQ-009 SHALL have port gen_start, input, 1, a one-cycle pulse that requests injection.
REQ-010 SHALL have port gen_num_pkts, input, 8, the number of packets to inject.
REQ-011 SHALL have port gen_len, input, 8, the payload length in words.
REQ-012 SHALL have port gen_pattern, input, 64, the payload pattern.
REQ-013 SHALL have port gen_busy, output, 1, high while any injected packets remain to be sent.
REQ-014 SHALL have port gen_sent, output, 32, the count of injected packets completed.

Function
REQ-015 SHALL buffer the upstream stream in a 4-deep fallthrough FIFO, with in_rdy = !nearly_full.
REQ-016 SHALL register out_data, out_ctrl and out_wr, so a word launched in cycle t appears at t+1.
REQ-017 SHALL launch a word only in a cycle where out_rdy=1; out_wr=0 in all other cycles.
REQ-018 SHALL have states IDLE (pass-through), HDR and BODY.
REQ-019 SHALL, in IDLE, pop and forward the FIFO head when the FIFO is not empty and out_rdy=1.
REQ-020 SHALL track pass_in_pkt: set when a ctrl=0xFF word is forwarded; cleared when a word with ctrl neither 0x00 nor 0xFF is forwarded.
REQ-021 SHALL move IDLE->HDR when remaining>0 and pass_in_pkt=0 (evaluated before any pop in that cycle), and SHALL NOT pop the FIFO in that cycle.
REQ-022 SHALL, in HDR with out_rdy=1, emit ctrl=0xFF and data={48'h0, len*8 as 16 bits}, then go to BODY with idx=1.
REQ-023 SHALL, in BODY with out_rdy=1, emit payload word idx:
- idx=1: data=pattern;
- otherwise: data=idx zero-extended;
- ctrl=0x01 when idx=len, else 0x00.
REQ-024 SHALL, on emitting idx=len: decrement remaining, increment gen_sent, and return to IDLE, so pass traffic gets one packet slot between injected packets.
REQ-025 SHALL hold state, idx and outputs-invalid while out_rdy=0 in HDR or BODY, with no word skipped or repeated.
REQ-026 SHALL, on gen_start while remaining=0, latch remaining=gen_num_pkts, len=max(gen_len,2) and pattern=gen_pattern.
REQ-027 SHALL ignore gen_start while remaining>0.
REQ-028 SHALL treat gen_num_pkts=0 as no request.
REQ-029 SHALL drive gen_busy = (remaining!=0) | (state!=IDLE).
REQ-030 SHALL let gen_sent wrap modulo 2^32.
REQ-031 SHALL leave pass-through data unmodified and in order, with no loss under backpressure.

Reset
REQ-032 SHALL, on reset, asynchronously force:
- state=IDLE, remaining=0, idx=0, pass_in_pkt=0;
- gen_sent=0, out_wr=0, out_data=0, out_ctrl=0;
- FIFO empty.
REQ-033 SHALL, on reset during HDR or BODY, abandon the partial packet and emit no further words of it.

Structure
REQ-034 SHALL place the ctrl codes (0xFF module header, 0x00 payload, 0x01 last) and the minimum length 2 in a shared package/defines file used with the ids block.
REQ-035 SHALL instantiate fallthrough_small_fifo (WIDTH=CTRL_WIDTH+DATA_WIDTH, MAX_DEPTH_BITS=2) as the one sub-module; the FSM is in the top.

Verification
REQ-036 SHALL cover this idle case: gen_start, num_pkts=1, len=3, pattern=64'h0102030405060708, out_rdy=1 -> out words (FF,len 24), (00,pattern), (00,2), (01,3); gen_sent=1; gen_busy falls after the last word.
REQ-037 SHALL cover start during pass traffic: gen_start while a 5-word pass packet is mid-flight -> the pass packet completes contiguously and the injected header follows it.
REQ-038 SHALL cover backpressure: out_rdy toggled 1010... during a num_pkts=2, len=4 injection -> exactly 10 words, correct order, out_wr never high the cycle after out_rdy=0.
REQ-039 SHALL cover interleaving: num_pkts=3 plus continuous pass traffic -> the output alternates injected and pass packets; gen_sent=3.
REQ-040 SHALL cover parameter limits: gen_len=0 -> a 2-word payload; gen_num_pkts=0 -> no injection; a second gen_start while busy -> ignored.
REQ-041 SHALL cover reset during BODY at idx=2 -> out_wr=0 immediately, gen_sent=0, gen_busy=0, and pass-through resumes after reset.
